// File: rtl/module_display_mux_if.sv
// Display bus between the operand display register side and the seven-segment mux.
// The master drives the operand nibbles and controls; the slave returns segments and anodes.
interface module_display_mux_if;
   logic [3:0] op_u;
   logic [3:0] op_d;
   logic       en;
   logic       blank_lz;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_tick;

   modport master (
      output op_u,
      output op_d,
      output en,
      output blank_lz,
      input  seg,
      input  an,
      input  frame_tick
   );

   modport slave (
      input  op_u,
      input  op_d,
      input  en,
      input  blank_lz,
      output seg,
      output an,
      output frame_tick
   );
endinterface

// File: rtl/module_display_mux.sv
// Two-digit multiplexed seven-segment driver: per-frame snapshot of both nibbles, hex decode,
// and a dark guard interval at the start of every digit slot.
module module_display_mux #(
   parameter int unsigned REFRESH_DIV = 13500,
   parameter int unsigned GUARD       = 64
) (
   input logic                 clk,
   input logic                 rst,
   module_display_mux_if.slave bus
);

   localparam int unsigned SlotW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [SlotW-1:0] SlotLast  = SlotW'(REFRESH_DIV - 1);
   localparam logic [SlotW-1:0] GuardLast = SlotW'(GUARD - 1);
   localparam logic [6:0]       SegOff    = 7'h7F;
   localparam logic [1:0]       AnOff     = 2'b11;

   // digit x guard/show; the guard states cover slots 0..GUARD-1 of each digit
   typedef enum logic [1:0] {
      StGuardU,
      StShowU,
      StGuardD,
      StShowD
   } state_e;

   state_e           state_q, state_d;
   logic [SlotW-1:0] slot_q, slot_d;
   logic [3:0]       snap_u_q, snap_u_d;
   logic [3:0]       snap_d_q, snap_d_d;
   logic [1:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick_q, tick_d;
   logic             frame_start;
   logic [3:0]       shown_nibble;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] glyph;
      unique case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = SegOff;
      endcase
      return glyph;
   endfunction

   assign frame_start = (state_q == StGuardU) && (slot_q == '0);

   // Slot counter, digit/guard state and frame snapshot
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q + SlotW'(1);
      snap_u_d = snap_u_q;
      snap_d_d = snap_d_q;

      if (frame_start) begin
         snap_u_d = bus.op_u;
         snap_d_d = bus.op_d;
      end

      if (slot_q == SlotLast) begin
         slot_d = '0;
         unique case (state_q)
            StGuardU, StShowU: state_d = StGuardD;
            StGuardD, StShowD: state_d = StGuardU;
            default:           state_d = StGuardU;
         endcase
      end else if (slot_q == GuardLast) begin
         unique case (state_q)
            StGuardU: state_d = StShowU;
            StGuardD: state_d = StShowD;
            default:  state_d = state_q;
         endcase
      end
   end

   // Registered outputs are derived from the pre-edge state and snapshot
   always_comb begin
      an_d         = AnOff;
      shown_nibble = snap_u_q;
      tick_d       = frame_start;

      unique case (state_q)
         StShowU: begin
            an_d         = 2'b10;
            shown_nibble = snap_u_q;
         end
         StShowD: begin
            shown_nibble = snap_d_q;
            an_d         = (bus.blank_lz && (snap_d_q == 4'h0)) ? AnOff : 2'b01;
         end
         default: an_d = AnOff;
      endcase

      if (!bus.en) begin
         an_d = AnOff;
      end

      seg_d = (an_d == AnOff) ? SegOff : hex_decode(shown_nibble);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StGuardU;
         slot_q   <= '0;
         snap_u_q <= 4'h0;
         snap_d_q <= 4'h0;
         an_q     <= AnOff;
         seg_q    <= SegOff;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         snap_u_q <= snap_u_d;
         snap_d_q <= snap_d_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         tick_q   <= tick_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_module_display_mux.sv
// Scoreboard bench for module_display_mux with REFRESH_DIV=8, GUARD=2: stimulus pushes the
// expected outputs for each edge, a monitor pops and compares just after every rising edge.
module tb_module_display_mux;

   localparam int unsigned Div   = 8;
   localparam int unsigned Grd   = 2;
   localparam int unsigned Frame = 2 * Div;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       tick;
   } exp_t;

   logic clk;
   logic rst;
   module_display_mux_if bus ();

   module_display_mux #(
      .REFRESH_DIV(Div),
      .GUARD      (Grd)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-low glyphs written out by hand from the decode table
   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   e     = 0;
   logic [3:0] bsu = 4'h0;
   logic [3:0] bsd = 4'h0;

   // Queue the expected outputs after the coming edge E<e>, then let that edge happen
   task automatic run_edge();
      exp_t x;
      int   p;
      int   s;
      logic is_d;
      if (!rst) begin
         x.an = 2'b11; x.seg = 7'h7F; x.tick = 1'b0;
         bsu = 4'h0; bsd = 4'h0; e = 0;
         exp_q.push_back(x);
      end else begin
         p    = e % Frame;
         s    = p % Div;
         is_d = (p >= Div);
         x.tick = (p == 0);
         if (!bus.en || s < Grd)            x.an = 2'b11;
         else if (!is_d)                    x.an = 2'b10;
         else if (bus.blank_lz && bsd == 0) x.an = 2'b11;
         else                               x.an = 2'b01;
         x.seg = (x.an == 2'b11) ? 7'h7F : glyph_tab[is_d ? bsd : bsu];
         exp_q.push_back(x);
         if (p == 0) begin
            bsu = bus.op_u;
            bsd = bus.op_d;
         end
         e++;
      end
      @(posedge clk);
      #2;
   endtask

   int n = 0;
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         exp_t x;
         x = exp_q.pop_front();
         tests++;
         if (bus.an !== x.an || bus.seg !== x.seg || bus.frame_tick !== x.tick) begin
            fails++;
            $display("FAIL out#%0d: got an=%b seg=%h tick=%b, need an=%b seg=%h tick=%b",
                     n, bus.an, bus.seg, bus.frame_tick, x.an, x.seg, x.tick);
         end
         n++;
      end
   end

   initial begin
      bus.op_u = 4'h7; bus.op_d = 4'h4; bus.en = 1'b1; bus.blank_lz = 1'b0;
      rst = 1'b0;
      repeat (3) run_edge();
      rst = 1'b1;

      // Static 4/7 with op_u changed mid-frame: units keep 78 until the next snapshot
      for (int k = 0; k < 2 * Frame; k++) begin
         if (e == 5) bus.op_u = 4'h3;
         run_edge();
      end

      // Leading-zero blanking, then the same zero shown
      bus.op_d = 4'h0; bus.blank_lz = 1'b1;
      repeat (Frame) run_edge();
      bus.blank_lz = 1'b0;
      repeat (Frame) run_edge();

      // Disabled frame keeps timing and frame_tick
      bus.en = 1'b0; bus.op_d = 4'hB;
      repeat (Frame) run_edge();
      bus.en = 1'b1;

      // Hex decode sweep on units
      for (int v = 0; v < 16; v++) begin
         bus.op_u = 4'(v);
         bus.op_d = 4'(15 - v);
         repeat (Frame) run_edge();
      end

      // Reset during the tens show slot
      bus.op_u = 4'h5; bus.op_d = 4'h2;
      repeat (12) run_edge();
      rst = 1'b0;
      repeat (2) run_edge();
      rst = 1'b1;
      repeat (Frame + 4) run_edge();

      repeat (2) @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/module_display_mux.md
# module_display_mux

Two-digit multiplexed seven-segment driver. It sits directly downstream of the operand display register and consumes its registered units/tens nibbles (`op_u`, `op_d`). Once per refresh frame it snapshots both nibbles and decodes them to hex glyphs. It then time-multiplexes a shared active-low segment bus across two active-low digit anodes, with a dark guard interval at every digit switch to suppress ghosting.

## Interface
- `REFRESH_DIV`, default 13500: clock cycles per digit slot (27 MHz gives a 1 kHz frame); must be > `GUARD`.
- `GUARD`, default 64: leading cycles of each slot with anodes off; must be ≥ 1.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `op_u` in 4: units nibble from the operand display register.
- `op_d` in 4: tens nibble from the operand display register.
- `en` in 1: display enable; 0 blanks the outputs while timing keeps running.
- `blank_lz` in 1: 1 blanks the tens digit when the snapshotted tens value is 0.
- `seg` out 7: {g,f,e,d,c,b,a}, active-low, registered.
- `an` out 2: {tens, units} anodes, active-low, registered.
- `frame_tick` out 1: one-cycle pulse marking a snapshot, registered.

## Operation
- Internal state:
  - `slot` counter, 0..`REFRESH_DIV`-1, width `$clog2(REFRESH_DIV)`.
  - `digit` select: U = 0, D = 1.
  - Snapshot registers `snap_u` and `snap_d`.
- Counting:
  - `slot` increments every cycle.
  - At `REFRESH_DIV`-1 it wraps to 0 and `digit` toggles.
  - Frame length is 2·`REFRESH_DIV` cycles.
- Effective state machine (`digit` × guard/show):
  - GUARD_U (digit=U, slot<GUARD) → SHOW_U (slot≥GUARD) → GUARD_D → SHOW_D → GUARD_U.
- Snapshot:
  - Taken on every edge where digit=U and slot=0: `snap_u`<=`op_u`, `snap_d`<=`op_d`.
  - Input changes at any other time have no effect until the next frame, so a digit never tears mid-frame.
- Output registers are computed each edge from the pre-edge `digit`/`slot`/`snap_*`:
  - `an`:
    - 2'b11 if `en`=0 or slot<GUARD.
    - Else 2'b10 when digit=U.
    - Else 2'b01 when digit=D, except 2'b11 if `blank_lz`=1 and `snap_d`=0.
  - `seg`:
    - 7'h7F whenever `an`=2'b11.
    - Otherwise the decode of `snap_u` or `snap_d` for the selected digit.
  - `frame_tick`: 1 iff digit=U and slot=0.
- Hex decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- `en` and `blank_lz` are sampled every cycle and are not snapshotted.

## Timing
- Reset values (edge with `rst`=0):
  - slot=0, digit=U, `snap_u`=`snap_d`=0.
  - `an`=2'b11, `seg`=7'h7F, `frame_tick`=0.
- Reset mid-frame aborts immediately. The next edge forces the reset values; no partial slot completes.
- Edge numbering: E0 is the first edge with `rst`=1.
  - E0: snapshot loads and `frame_tick`=1 during the following cycle.
  - E`GUARD`: units anode asserts.
  - E`REFRESH_DIV`: units goes dark.
  - E(`REFRESH_DIV`+`GUARD`): tens asserts.
  - E(2·`REFRESH_DIV`): next snapshot.
- Latency: input to visible glyph is at most 2·`REFRESH_DIV`+`GUARD`+1 cycles.
- At most one anode is ever low. Both are high for ≥ `GUARD` cycles between digits.

## Test plan
- Run with `REFRESH_DIV`=8, `GUARD`=2 for all directed scenarios.
- Static 4/7 display: `op_u`=7, `op_d`=4, release reset → `frame_tick`=1 after E0; `an`=10, `seg`=78 after E2..E7; `an`=11 after E8..E9; `an`=01, `seg`=19 after E10..E15; `frame_tick`=1 after E16.
- Snapshot isolation: change `op_u` from 7 to 3 at cycle 5 → units still show 78 through E7; 30 appears after E18.
- Leading-zero blanking: `op_d`=0, `blank_lz`=1 → `an` stays 11 and `seg` stays 7F through the tens slot. With `blank_lz`=0 → `an`=01, `seg`=40.
- Enable and hex decode: `en`=0 for a full frame → `an`=11, `seg`=7F throughout, and `frame_tick` still pulses every 16 cycles. Then sweep `op_u` 0..F → each decode matches the table.
- Reset mid-show: assert `rst`=0 at E12 → after E12, `an`=11, `seg`=7F, `frame_tick`=0. On release, the sequence restarts at E0 with `snap`=0 until reload.
